adder_share_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one combinational 4-bit adder (`async_adder`-style: A, B in, SUM out, carry preserved) among several requesters. Each requester presents an operand pair under a valid/ready handshake. The block grants one requester at a time, drives the shared adder from registered operands, captures the sum after one settle cycle, and returns it tagged with the requester index. It sits between client logic and the single adder instance.

---
 rtl/adder_share_arbiter.sv | 77 +++++++
 tb/tb_adder_share_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: round-robin sharing of one external adder among NREQ requesters.
// Optional sum self-check enabled by defining ADDER_SHARE_ARBITER_CHECK_EN.
module adder_share_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]      add_a,
  output logic [WIDTH-1:0]      add_b,
  input  logic [WIDTH:0]        add_sum,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH:0]        rsp_sum,
  output logic                  chk_err
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_nxt;
  logic [IDW-1:0] rr_ptr, gnt_id;
  logic gnt_any;
  logic [WIDTH-1:0] sel_a, sel_b;
  // scan downward so the nearest valid requester at/after rr_ptr wins last
  always_comb begin
    gnt_any = 1'b0;
    gnt_id = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (req_valid[(int'(rr_ptr) + k) % NREQ]) begin
        gnt_any = 1'b1;
        gnt_id = IDW'((int'(rr_ptr) + k) % NREQ);
      end
  end
  always_comb begin
    state_nxt = state == IDLE ? (gnt_any ? EXEC : IDLE) :
                state == EXEC ? RESP : (rsp_ready ? IDLE : RESP);
    req_ready = (rst_n && state == IDLE && gnt_any) ? {{(NREQ-1){1'b0}}, 1'b1} << gnt_id : '0;
    sel_a = req_a[int'(gnt_id) * WIDTH +: WIDTH];
    sel_b = req_b[int'(gnt_id) * WIDTH +: WIDTH];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      rr_ptr <= '0;
      add_a <= '0;
      add_b <= '0;
      rsp_id <= '0;
      rsp_sum <= '0;
      rsp_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && gnt_any) begin
        add_a <= sel_a;
        add_b <= sel_b;
        rsp_id <= gnt_id;
        rr_ptr <= gnt_id == IDW'(NREQ - 1) ? '0 : gnt_id + 1'b1;
      end
      if (state == EXEC) begin
        rsp_sum <= add_sum;
        rsp_valid <= 1'b1;
      end
      if (state == RESP && rsp_ready) rsp_valid <= 1'b0;
    end
`ifdef ADDER_SHARE_ARBITER_CHECK_EN
  logic [WIDTH:0] ref_sum;
  assign ref_sum = {1'b0, add_a} + {1'b0, add_b};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) chk_err <= 1'b0;
    else if (state == EXEC && add_sum != ref_sum) chk_err <= 1'b1;
`else
  assign chk_err = 1'b0;
`endif
endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb_adder_share_arbiter: scoreboard bench; a transaction-level round-robin model predicts
// response order and sums, a negedge monitor checks responses, latency and stall stability.
module tb_adder_share_arbiter;
  localparam int NREQ = 4, W = 4, IDW = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [NREQ-1:0] req_valid, req_ready;
  logic [NREQ*W-1:0] req_a, req_b;
  logic [W-1:0] add_a, add_b;
  logic [W:0] add_sum, rsp_sum;
  logic rsp_valid, rsp_ready, chk_err;
  logic [IDW-1:0] rsp_id;
  logic fault = 1'b0;
  assign add_sum = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, fault};
  always #5 clk = ~clk;
  adder_share_arbiter #(.NREQ(NREQ), .WIDTH(W), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
    .chk_err(chk_err));
  typedef struct {int id; int sum;} exp_t;
  exp_t exp_q[$];
  exp_t e;
  int total = 0, bad = 0, cyc = 0, acc_edge = -100, mptr = 0;
  int rise_q[$];
  bit prev_valid = 0, stalled = 0, hold = 0, rnd = 0;
  logic [IDW-1:0] h_id;
  logic [W:0] h_sum;
  logic [W-1:0] op_a[NREQ], op_b[NREQ];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 rsp_ready = hold ? 1'b0 : rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end
  always @(negedge clk)
    if (rst_n) begin
      chk("ready_onehot", 32'($onehot0(req_ready)), 1);
      if (|req_ready) acc_edge = cyc + 1;
      if (rsp_valid && !prev_valid) begin
        chk("latency", cyc, acc_edge + 1);
        rise_q.push_back(cyc);
      end
      if (stalled) begin
        chk("stall_valid", rsp_valid, 1);
        chk("stall_id", rsp_id, h_id);
        chk("stall_sum", rsp_sum, h_sum);
        chk("stall_req_ready", req_ready, 0);
      end
      stalled = rsp_valid && !rsp_ready;
      h_id = rsp_id;
      h_sum = rsp_sum;
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) chk("unexpected_rsp", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("rsp_id", rsp_id, e.id);
          chk("rsp_sum", rsp_sum, e.sum);
        end
      end
      prev_valid = rsp_valid;
    end else begin
      prev_valid = 0;
      stalled = 0;
    end
  task automatic drive_ops(input logic [NREQ-1:0] set);
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*W +: W] = op_a[i];
      req_b[i*W +: W] = op_b[i];
    end
    req_valid = set;
  endtask
  // model: all requesters in set are valid together, so grants follow cyclic order from the pointer
  task automatic run_round(input logic [NREQ-1:0] set);
    int last = 0, budget = 0;
    logic [NREQ-1:0] pend, a;
    for (int k = 0; k < NREQ; k++) begin
      int i = (mptr + k) % NREQ;
      if (set[i]) begin
        exp_q.push_back('{id: i, sum: int'(op_a[i]) + int'(op_b[i]) + int'(fault)});
        last = i;
      end
    end
    mptr = (last + 1) % NREQ;
    @(posedge clk);
    #1 drive_ops(set);
    pend = set;
    while (pend != 0 && budget < 200) begin
      @(negedge clk);
      a = req_ready;
      @(posedge clk);
      #1 pend &= ~a;
      req_valid = pend;
      budget++;
    end
    if (pend != 0) chk("accept_timeout", 32'(pend), 0);
    req_valid = '0;
    budget = 0;
    while (exp_q.size() != 0 && budget < 300) begin
      @(negedge clk);
      budget++;
    end
    if (exp_q.size() != 0) begin
      chk("rsp_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask
  task automatic check_reset_outputs();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_add_a", add_a, 0);
    chk("rst_add_b", add_b, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_sum", rsp_sum, 0);
    chk("rst_chk_err", chk_err, 0);
  endtask
  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1 check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    mptr = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int budget;
    logic [NREQ-1:0] set;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    #1 check_reset_outputs();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    op_a[0] = 1; op_b[0] = 2;
    run_round(4'b0001);
    op_a[2] = 15; op_b[2] = 1;
    run_round(4'b0100);
    op_a[2] = 10; op_b[2] = 5;
    run_round(4'b0100);
    // all four contend right after reset: order 0,1,2,3 at 3-cycle spacing, then 0 again
    pulse_reset();
    op_a[0] = 1; op_b[0] = 2; op_a[1] = 5; op_b[1] = 3;
    op_a[2] = 10; op_b[2] = 5; op_a[3] = 15; op_b[3] = 1;
    rise_q.delete();
    run_round(4'b1111);
    chk("rise_count", rise_q.size(), 4);
    if (rise_q.size() == 4)
      for (int k = 0; k < 3; k++) chk("issue_interval", rise_q[k+1] - rise_q[k], 3);
    run_round(4'b0001);
    // backpressure while another requester waits
    hold = 1;
    fork
      run_round(4'b1001);
      begin
        budget = 0;
        do begin
          @(negedge clk);
          budget++;
        end while (!rsp_valid && budget < 50);
        chk("bp_seen_valid", rsp_valid, 1);
        repeat (5) begin
          @(negedge clk);
          #1 chk("bp_valid_held", rsp_valid, 1);
          chk("bp_req_ready", req_ready, 0);
        end
        hold = 0;
      end
    join
    // reset during EXEC drops the operation and rewinds the pointer
    op_a[2] = 7; op_b[2] = 6;
    @(posedge clk);
    #1 drive_ops(4'b0100);
    budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while (!req_ready[2] && budget < 50);
    chk("midrst_accept", req_ready[2], 1);
    @(posedge clk);
    #1 req_valid = '0;
    rst_n = 1'b0;
    #1 check_reset_outputs();
    repeat (3) begin
      @(negedge clk);
      chk("midrst_no_rsp", rsp_valid, 0);
    end
    rst_n = 1'b1;
    mptr = 0;
    op_a[1] = 3; op_b[1] = 4; op_a[3] = 9; op_b[3] = 9;
    run_round(4'b1010);
    rnd = 1;
    repeat (40) begin
      set = NREQ'($urandom_range(1, 15));
      for (int i = 0; i < NREQ; i++) begin
        op_a[i] = W'($urandom);
        op_b[i] = W'($urandom);
      end
      run_round(set);
    end
    rnd = 0;
`ifdef ADDER_SHARE_ARBITER_CHECK_EN
    chk("chk_err_clean", chk_err, 0);
    fault = 1'b1;
    op_a[0] = 1; op_b[0] = 2;
    run_round(4'b0001);
    chk("chk_err_set", chk_err, 1);
    fault = 1'b0;
    run_round(4'b0001);
    chk("chk_err_sticky", chk_err, 1);
`else
    chk("chk_err_tied", chk_err, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
